// File: rtl/serial_neuron.sv
// Serial multiply-accumulate neuron: LANES products per cycle over M inputs,
// followed by optional ReLU and saturation to a signed OUT_W result.
module serial_neuron #(
  parameter int K     = 4,
  parameter int N     = 4,
  parameter int B     = 4,
  parameter int M     = 4,
  parameter int LANES = 1,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M*K-1:0]   activation_input,
  input  logic [M*N-1:0]   weight,
  input  logic [B-1:0]     bias,
  input  logic             act_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] res,
  output logic             sat
);

  localparam int ACC_W = ((K + N > B) ? K + N : B) + $clog2(M + 1) + 1;
  localparam int STEPS = M / LANES;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam int CMP_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  typedef enum logic [1:0] {IDLE, MAC, FIN, HOLD} state_t;

  state_t                   state_q, state_d;
  logic [M*K-1:0]           act_q, act_d;
  logic [M*N-1:0]           wgt_q, wgt_d;
  logic                     mode_q, mode_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         step_q, step_d;
  logic [OUT_W-1:0]         res_q, res_d;
  logic                     sat_q, sat_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [K-1:0]      a_el;
  logic signed [N-1:0]      w_el;
  logic signed [K+N-1:0]    prod;
  logic signed [ACC_W-1:0]  mac_sum;
  logic signed [ACC_W-1:0]  relu_val;
  logic signed [CMP_W-1:0]  relu_ext, max_v, min_v, clip_val;
  logic                     clip;

  // Sum of this step's LANES full-precision products, sign-extended to ACC_W
  always_comb begin
    mac_sum = '0;
    a_el    = '0;
    w_el    = '0;
    prod    = '0;
    for (int l = 0; l < LANES; l++) begin
      a_el    = act_q[(int'(step_q) * LANES + l) * K +: K];
      w_el    = wgt_q[(int'(step_q) * LANES + l) * N +: N];
      prod    = a_el * w_el;
      mac_sum = mac_sum + {{(ACC_W-K-N){prod[K+N-1]}}, prod};
    end
  end

  // ReLU then clip; compared in a width wider than both acc and result
  always_comb begin
    relu_val = (mode_q && acc_q[ACC_W-1]) ? '0 : acc_q;
    relu_ext = {{(CMP_W-ACC_W){relu_val[ACC_W-1]}}, relu_val};
    max_v    = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    min_v    = {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    clip     = 1'b0;
    clip_val = relu_ext;
    if (relu_ext > max_v) begin
      clip_val = max_v;
      clip     = 1'b1;
    end else if (relu_ext < min_v) begin
      clip_val = min_v;
      clip     = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    wgt_d       = wgt_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    step_d      = step_q;
    res_d       = res_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          act_d   = activation_input;
          wgt_d   = weight;
          mode_d  = act_mode;
          acc_d   = {{(ACC_W-B){bias[B-1]}}, bias};
          step_d  = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d  = acc_q + mac_sum;
        step_d = step_q + CNT_W'(1);
        if (step_q == CNT_W'(STEPS - 1)) state_d = FIN;
      end
      FIN: begin
        res_d       = clip_val[OUT_W-1:0];
        sat_d       = clip;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      act_q       <= '0;
      wgt_q       <= '0;
      mode_q      <= 1'b0;
      acc_q       <= '0;
      step_q      <= '0;
      res_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      wgt_q       <= wgt_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      res_q       <= res_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_serial_neuron.sv
// Bench for serial_neuron: three instances (LANES = 1, 2, 4) share one stimulus
// stream and are compared against an arithmetic reference model.
module tb_serial_neuron;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] activation_input;
  logic [15:0] weight;
  logic [3:0]  bias;
  logic        act_mode;
  logic        out_ready;

  logic        in_ready_v  [3];
  logic        out_valid_v [3];
  logic [7:0]  res_v       [3];
  logic        sat_v       [3];

  int steps_of [3] = '{4, 2, 1};
  int assert_count = 0;
  int fail_count   = 0;

  serial_neuron #(.LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .activation_input(activation_input), .weight(weight), .bias(bias),
    .act_mode(act_mode), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .res(res_v[0]), .sat(sat_v[0]));

  serial_neuron #(.LANES(2)) u_l2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .activation_input(activation_input), .weight(weight), .bias(bias),
    .act_mode(act_mode), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .res(res_v[1]), .sat(sat_v[1]));

  serial_neuron #(.LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .activation_input(activation_input), .weight(weight), .bias(bias),
    .act_mode(act_mode), .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .res(res_v[2]), .sat(sat_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports tag, instance, observed and expected on failure
  task automatic checkOutput(input string tag, input int d,
                             input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s lanes_inst=%0d observed=%0d expected=%0d", tag, d, observed, expected);
    end
  endtask

  // Reference: bias plus dot product, optional ReLU, clip to signed 8 bits
  task automatic computeModel(input int a[4], input int w[4], input int b, input int mode,
                              output int r, output int s);
    int sum;
    sum = b;
    for (int i = 0; i < 4; i++) sum += a[i] * w[i];
    if (mode != 0 && sum < 0) sum = 0;
    s = (sum > 127 || sum < -128) ? 1 : 0;
    r = (sum > 127) ? 127 : (sum < -128) ? -128 : sum;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set, let the accept edge pass, then scramble the inputs
  task automatic applyStimulus(input int a[4], input int w[4], input int b, input int mode);
    for (int i = 0; i < 4; i++) begin
      activation_input[i*4 +: 4] = 4'(a[i]);
      weight[i*4 +: 4]           = 4'(w[i]);
    end
    bias     = 4'(b);
    act_mode = mode[0];
    in_valid = 1'b1;
    for (int d = 0; d < 3; d++) checkOutput("in_ready_before_accept", d, 32'(in_ready_v[d]), 1);
    stepClock();
    in_valid         = 1'b0;
    activation_input = 16'($urandom);
    weight           = 16'($urandom);
    bias             = 4'($urandom);
    act_mode         = 1'($urandom);
  endtask

  // Watch each instance for its result and check latency, res and sat
  task automatic collectResults(input int exp_res, input int exp_sat);
    bit seen [3];
    for (int d = 0; d < 3; d++) seen[d] = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      stepClock();
      for (int d = 0; d < 3; d++) begin
        if (!seen[d] && out_valid_v[d] === 1'b1) begin
          seen[d] = 1'b1;
          checkOutput("latency", d, cyc, steps_of[d] + 1);
          checkOutput("res", d, $signed(res_v[d]), exp_res);
          checkOutput("sat", d, 32'(sat_v[d]), exp_sat);
        end
      end
    end
    for (int d = 0; d < 3; d++) checkOutput("result_seen", d, 32'(seen[d]), 1);
  endtask

  task automatic runOp(input int a[4], input int w[4], input int b, input int mode);
    int r, s;
    computeModel(a, w, b, mode, r, s);
    applyStimulus(a, w, b, mode);
    collectResults(r, s);
  endtask

  initial begin
    int a[4], w[4];
    int r, s;
    bit all_valid;

    rst              = 1'b1;
    in_valid         = 1'b0;
    activation_input = '0;
    weight           = '0;
    bias             = '0;
    act_mode         = 1'b0;
    out_ready        = 1'b1;
    stepClock();
    stepClock();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      checkOutput("reset_in_ready", d, 32'(in_ready_v[d]), 1);
      checkOutput("reset_out_valid", d, 32'(out_valid_v[d]), 0);
      checkOutput("reset_res", d, $signed(res_v[d]), 0);
      checkOutput("reset_sat", d, 32'(sat_v[d]), 0);
    end

    // Identity basic: 1+2+3+4 = 10
    a = '{1, 2, 3, 4};     w = '{1, 1, 1, 1};     runOp(a, w, 0, 0);
    // Negative saturation, then the same with ReLU
    a = '{-8, -8, -8, -8}; w = '{7, 7, 7, 7};     runOp(a, w, -8, 0);
    runOp(a, w, -8, 1);
    // Positive saturation: 256 + 7 = 263
    a = '{-8, -8, -8, -8}; w = '{-8, -8, -8, -8}; runOp(a, w, 7, 0);

    // Backpressure with a competing operand set offered throughout
    out_ready = 1'b0;
    a = '{1, 2, 3, 4}; w = '{1, 1, 1, 1};
    computeModel(a, w, 0, 0, r, s);
    applyStimulus(a, w, 0, 0);
    in_valid         = 1'b1;
    activation_input = 16'hFFFF;
    weight           = 16'h7777;
    all_valid        = 1'b0;
    for (int cyc = 1; cyc <= 8 && !all_valid; cyc++) begin
      stepClock();
      all_valid = out_valid_v[0] && out_valid_v[1] && out_valid_v[2];
    end
    checkOutput("bp_all_valid", 0, 32'(all_valid), 1);
    for (int cyc = 0; cyc < 10; cyc++) begin
      stepClock();
      for (int d = 0; d < 3; d++) begin
        checkOutput("bp_out_valid", d, 32'(out_valid_v[d]), 1);
        checkOutput("bp_in_ready", d, 32'(in_ready_v[d]), 0);
        checkOutput("bp_res", d, $signed(res_v[d]), r);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stepClock();
    for (int d = 0; d < 3; d++) begin
      checkOutput("bp_release_in_ready", d, 32'(in_ready_v[d]), 1);
      checkOutput("bp_release_out_valid", d, 32'(out_valid_v[d]), 0);
    end

    // Reset during the second MAC cycle aborts the operation
    a = '{3, -2, 5, 1}; w = '{2, 2, -1, 4};
    applyStimulus(a, w, 1, 0);
    stepClock();
    rst = 1'b1;
    stepClock();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      checkOutput("abort_in_ready", d, 32'(in_ready_v[d]), 1);
      checkOutput("abort_out_valid", d, 32'(out_valid_v[d]), 0);
      checkOutput("abort_res", d, $signed(res_v[d]), 0);
    end
    for (int cyc = 0; cyc < 8; cyc++) begin
      stepClock();
      for (int d = 0; d < 3; d++) checkOutput("abort_no_valid", d, 32'(out_valid_v[d]), 0);
    end
    runOp(a, w, 1, 0);

    // Random regression
    for (int n = 0; n < 100; n++) begin
      int b, mode;
      for (int i = 0; i < 4; i++) begin
        a[i] = int'($urandom_range(0, 15)) - 8;
        w[i] = int'($urandom_range(0, 15)) - 8;
      end
      b    = int'($urandom_range(0, 15)) - 8;
      mode = int'($urandom_range(0, 1));
      runOp(a, w, b, mode);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/serial_neuron.md
SERIAL_NEURON -- requirements
Module: serial_neuron

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- K, 4, activation element width, signed.
- N, 4, weight element width, signed.
- B, 4, bias width, signed.
- M, 4, number of inputs per neuron.
- LANES, 1, products per cycle; M SHALL be divisible by LANES.
- OUT_W, 8, output width, signed.
REQ-002 SHALL derive localparams:
- ACC_W = max(K+N, B) + $clog2(M+1) + 1.
- STEPS = M/LANES.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge.
- rst, in, 1, synchronous, active-high reset.
- in_valid, in, 1, operand set offered.
- in_ready, out, 1, block can accept an operand set.
- activation_input, in, M*K, element i at bits [i*K +: K].
- weight, in, M*N, element i at bits [i*N +: N].
- bias, in, B, signed bias.
- act_mode, in, 1, 0 = identity, 1 = ReLU.
- out_valid, out, 1, result available.
- out_ready, in, 1, consumer accepts result.
- res, out, OUT_W, signed neuron output.
- sat, out, 1, res was clipped.

Function
REQ-004 SHALL implement FSM states IDLE, MAC, FIN, HOLD.
REQ-005 in_ready SHALL be 1 only in IDLE. An accept SHALL occur on an edge where in_valid && in_ready.
REQ-006 On accept, SHALL register activation_input, weight and act_mode, load acc with sign-extended bias, clear the step counter, and go to MAC. Inputs SHALL be don't-care afterwards.
REQ-007 Each MAC cycle SHALL add LANES signed products of registered elements [s*LANES .. s*LANES+LANES-1] to acc, where s is the step count. Each product SHALL be full precision K+N, sign-extended to ACC_W. The step counter SHALL increment each MAC cycle.
REQ-008 After STEPS MAC cycles, SHALL go to FIN. In FIN:
- ReLU is applied when act_mode=1: negative acc becomes 0.
- The result is then saturated to the signed OUT_W range.
- res and sat are registered, out_valid is set, and the FSM goes to HOLD.
REQ-009 sat SHALL be 1 iff the post-ReLU value lies outside [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-010 Latency: out_valid SHALL rise exactly STEPS+1 cycles after the accept edge.
REQ-011 In HOLD, res, sat and out_valid SHALL remain stable until out_ready=1. On that edge, out_valid SHALL clear and the FSM SHALL go to IDLE. in_ready SHALL be 1 in the following cycle; back-to-back accept in the same cycle is not supported.
REQ-012 out_ready SHALL be ignored outside HOLD. in_valid SHALL be ignored outside IDLE.
REQ-013 acc SHALL never overflow for any operand values, by the choice of ACC_W.
REQ-014 The block SHALL operate correctly for LANES=M (STEPS=1) and for LANES=1.

Reset
REQ-015 With rst=1 at an edge, the block SHALL return to IDLE with:
- in_ready=1 (asserted from the first cycle after reset deasserts), out_valid=0, res=0, sat=0.
- acc and step counter cleared.
REQ-016 Reset in any state, including mid-MAC or in HOLD with a pending result, SHALL abort the operation; no out_valid SHALL follow.
REQ-017 rst SHALL take priority over in_valid and out_ready on the same edge.

Verification
Defaults K=N=B=M=4, LANES=1, OUT_W=8, out_ready=1 unless stated.
REQ-018 Identity, basic:
- Stimulus: a=(1,2,3,4), w=(1,1,1,1), bias=0, act_mode=0.
- Response: res=10, sat=0, out_valid 5 cycles after accept.
REQ-019 Negative saturation and ReLU:
- a=(-8,-8,-8,-8), w=(7,7,7,7), bias=-8, act_mode=0: res=-128, sat=1.
- Same operands with act_mode=1: res=0, sat=0.
REQ-020 Positive saturation:
- Stimulus: a=(-8,-8,-8,-8), w=(-8,-8,-8,-8), bias=7.
- Response: sum 263, res=127, sat=1.
REQ-021 Backpressure:
- Hold out_ready=0 for 10 cycles after out_valid rises; present a new in_valid throughout.
- Response: res stable, in_ready=0, no accept. After out_ready=1, in_ready=1 next cycle.
REQ-022 Reset mid-operation:
- Assert rst during the 2nd MAC cycle.
- Response: out_valid stays 0, res=0, in_ready=1 from the first cycle after rst deasserts. A following operation gives the correct result.
REQ-023 Lanes:
- LANES=2, same operands as REQ-018.
- Response: res=10, out_valid 3 cycles after accept.
- Random regression: 100 operand sets against a reference model for LANES in {1,2,4}.
